// File: rtl/store_merge_unit.sv
// Read-modify-write sequencer for sw/sh/sb: merges the store operand into the
// addressed memory word and drives the write-data mux select and write strobe.
module store_merge_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        write_data_sel,
    output logic [31:0] wc_out,
    output logic        busy,
    output logic        done,
    output logic        store_fault
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    state_t        state;
    logic [CW-1:0] cnt;
    size_t         size_q;
    logic [1:0]    lane_q;
    logic [15:0]   data_q;
    logic [31:0]   rdata_q;
    logic          fault_q;
    logic          fault_req;

    // Little-endian lane replacement; bits outside the stored lane(s) pass through.
    function automatic logic [31:0] merge_word(
        input logic [31:0] word,
        input logic [15:0] data,
        input size_t       sz,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        if (sz == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = data[7:0];
        end else if (lane[1]) begin
            r[31:16] = data;
        end else begin
            r[15:0] = data;
        end
        return r;
    endfunction

    assign fault_req = (size == SZ_BAD) || ((size == SZ_HALF) && addr[0]);

    // NOTE: operand latches (size_q, lane_q, data_q, rdata_q) are always written
    // before they are read, so they carry no reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mem_addr <= '0;
            wc_out   <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q   <= size_t'(size);
                        lane_q   <= addr[1:0];
                        data_q   <= store_data[15:0];
                        mem_addr <= {addr[31:2], 2'b00};
                        fault_q  <= fault_req;
                        if (fault_req) begin
                            state <= S_DONE;
                        end else if (size == SZ_WORD) begin
                            wc_out <= store_data;
                            state  <= S_WRITE;
                        end else begin
                            cnt   <= CW'(MEM_LATENCY);
                            state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Read data is valid on the last of the MEM_LATENCY wait cycles.
                    if (cnt == CW'(1)) begin
                        rdata_q <= mem_rdata;
                        state   <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    wc_out <= merge_word(rdata_q, data_q, size_q, lane_q);
                    state  <= S_WRITE;
                end
                S_WRITE: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe and mux select are gated by reset so an abort in WRITE drops the write.
    assign mem_wr         = (state == S_WRITE) && !reset;
    assign write_data_sel = (state == S_WRITE) && !reset;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign store_fault    = (state == S_DONE) && fault_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: table of stores run on MEM_LATENCY=1 and =3 instances,
// expected records queued at issue and compared at completion, plus reset-abort sequences.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        start1, start3;
    logic [31:0] rdata1, rdata3;

    logic [31:0] a1_addr, a1_wc, a3_addr, a3_wc;
    logic        a1_wr, a1_wds, a1_busy, a1_done, a1_fault;
    logic        a3_wr, a3_wds, a3_busy, a3_done, a3_fault;

    always #5 clk = ~clk;

    store_merge_unit #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr),
        .store_data(store_data), .mem_rdata(rdata1), .mem_addr(a1_addr),
        .mem_wr(a1_wr), .write_data_sel(a1_wds), .wc_out(a1_wc),
        .busy(a1_busy), .done(a1_done), .store_fault(a1_fault)
    );

    store_merge_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr),
        .store_data(store_data), .mem_rdata(rdata3), .mem_addr(a3_addr),
        .mem_wr(a3_wr), .write_data_sel(a3_wds), .wc_out(a3_wc),
        .busy(a3_busy), .done(a3_done), .store_fault(a3_fault)
    );

    typedef struct {
        logic        l3;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] wc;
        logic [31:0] maddr;
        logic        fault;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic        sel;
    logic [31:0] o_addr, o_wc;
    logic        o_wr, o_wds, o_busy, o_done, o_fault;

    always_comb begin
        o_addr  = sel ? a3_addr  : a1_addr;
        o_wc    = sel ? a3_wc    : a1_wc;
        o_wr    = sel ? a3_wr    : a1_wr;
        o_wds   = sel ? a3_wds   : a1_wds;
        o_busy  = sel ? a3_busy  : a1_busy;
        o_done  = sel ? a3_done  : a1_done;
        o_fault = sel ? a3_fault : a1_fault;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    task automatic drive_rdata(input logic [31:0] v);
        if (sel) rdata3 = v;
        else     rdata1 = v;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v, e;
        int          lat, t, wr_cnt, wr_t, done_t, exp_done, exp_wr;
        logic [31:0] wr_wc, wr_addr, done_wc, done_addr;
        logic        wr_wds, flt, busy1;
        v = vecs[idx];
        sel = v.l3;
        lat = v.l3 ? 3 : 1;
        @(negedge clk);
        size = v.size; addr = v.addr; store_data = v.data;
        set_start(1'b1);
        drive_rdata($urandom);
        sb.push_back(v);
        @(posedge clk);
        t = 0; wr_cnt = 0; wr_t = 0; done_t = 0; busy1 = 1'b0; flt = 1'b0; wr_wds = 1'b0;
        wr_wc = '0; wr_addr = '0; done_wc = '0; done_addr = '0;
        while (done_t == 0 && t < 20) begin
            @(negedge clk);
            t++;
            if (t == 1) busy1 = o_busy;
            if (o_wr) begin
                wr_cnt++; wr_t = t; wr_wc = o_wc; wr_addr = o_addr; wr_wds = o_wds;
            end
            if (o_done) begin
                done_t = t; flt = o_fault; done_wc = o_wc; done_addr = o_addr;
            end
            // Stray start and scrambled inputs while busy; memory data valid only at capture.
            set_start(t == 1);
            size = 2'($urandom); addr = $urandom; store_data = $urandom;
            drive_rdata(t == lat ? v.rdata : $urandom);
        end
        e = sb.pop_front();
        exp_done = e.fault ? 1 : ((e.size == 2'b00) ? 2 : lat + 3);
        exp_wr   = (e.size == 2'b00) ? 1 : lat + 2;
        check($sformatf("v%0d done_seen", idx), done_t != 0, 1'b1);
        check($sformatf("v%0d done_time", idx), done_t, exp_done);
        check($sformatf("v%0d busy_after_accept", idx), busy1, 1'b1);
        check($sformatf("v%0d store_fault", idx), flt, e.fault);
        check($sformatf("v%0d write_count", idx), wr_cnt, e.fault ? 0 : 1);
        check($sformatf("v%0d mem_addr", idx), done_addr, e.maddr);
        check($sformatf("v%0d wc_at_done", idx), done_wc, e.wc);
        if (!e.fault) begin
            check($sformatf("v%0d write_time", idx), wr_t, exp_wr);
            check($sformatf("v%0d wc_at_write", idx), wr_wc, e.wc);
            check($sformatf("v%0d addr_at_write", idx), wr_addr, e.maddr);
            check($sformatf("v%0d wdsel_at_write", idx), wr_wds, 1'b1);
        end
        @(negedge clk);
        set_start(1'b0);
        check($sformatf("v%0d idle_after_done", idx), o_busy, 1'b0);
        check($sformatf("v%0d single_done", idx), o_done, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d no_restart", idx), o_busy, 1'b0);
        check($sformatf("v%0d wc_hold", idx), o_wc, e.wc);
        check($sformatf("v%0d addr_hold", idx), o_addr, e.maddr);
    endtask

    task automatic quiet_window(input string name);
        int n_done, n_wr;
        n_done = 0; n_wr = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_done) n_done++;
            if (o_wr)   n_wr++;
        end
        check({name, " no_done"}, n_done, 0);
        check({name, " no_write"}, n_wr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        //               l3    size   addr          data          rdata         wc            maddr         fault
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 32'h0000_0010, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 32'h0000_0022, 32'hFFFF_5566, 32'h1122_3344, 32'h5566_3344, 32'h0000_0020, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 32'h0000_0021, 32'h0000_9999, 32'hFFFF_FFFF, 32'h5566_3344, 32'h0000_0020, 1'b1};
        vecs[4]  = '{1'b0, 2'b11, 32'h0000_0044, 32'h1234_5678, 32'hFFFF_FFFF, 32'h5566_3344, 32'h0000_0044, 1'b1};
        vecs[5]  = '{1'b0, 2'b10, 32'h0000_0101, 32'hFFFF_FF77, 32'hAABB_CCDD, 32'hAABB_77DD, 32'h0000_0100, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 32'h0000_0008, 32'h0000_1234, 32'hAABB_CCDD, 32'hAABB_1234, 32'h0000_0008, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 32'h0000_0006, 32'h1234_56EE, 32'h0000_0000, 32'h00EE_0000, 32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 32'h0000_0033, 32'h0102_0304, 32'h0000_0000, 32'h0102_0304, 32'h0000_0030, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0012, 32'hCAFE_BABE, 32'hCAFE_BA12, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 32'h0000_1002, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 32'h0000_1000, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 32'h0000_0008, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'h0000_0008, 1'b0};
        vecs[12] = '{1'b1, 2'b11, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0005, 32'h0000_0004, 1'b1};

        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
        size = '0; addr = '0; store_data = '0; rdata1 = '0; rdata3 = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            check($sformatf("reset%0d busy", d), o_busy, 1'b0);
            check($sformatf("reset%0d done", d), o_done, 1'b0);
            check($sformatf("reset%0d mem_wr", d), o_wr, 1'b0);
            check($sformatf("reset%0d wdsel", d), o_wds, 1'b0);
            check($sformatf("reset%0d fault", d), o_fault, 1'b0);
            check($sformatf("reset%0d wc_out", d), o_wc, 32'h0);
            check($sformatf("reset%0d mem_addr", d), o_addr, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i);

        // Reset while waiting on the memory read aborts the byte store.
        sel = 1'b0;
        @(negedge clk);
        size = 2'b10; addr = 32'h0000_0055; store_data = 32'h0000_0066; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_rd busy_before", o_busy, 1'b1);
        start1 = 1'b0; reset = 1'b1; rdata1 = 32'h5555_5555;
        @(negedge clk);
        check("rst_rd busy", o_busy, 1'b0);
        check("rst_rd done", o_done, 1'b0);
        check("rst_rd mem_wr", o_wr, 1'b0);
        check("rst_rd wc_out", o_wc, 32'h0);
        check("rst_rd mem_addr", o_addr, 32'h0);
        reset = 1'b0;
        quiet_window("rst_rd");

        // Reset during WRITE suppresses the strobe in the same cycle.
        @(negedge clk);
        size = 2'b00; addr = 32'h0000_0040; store_data = 32'h0BAD_F00D; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        check("rst_wr strobe_before", o_wr, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_wr mem_wr_gated", o_wr, 1'b0);
        check("rst_wr wdsel_gated", o_wds, 1'b0);
        @(negedge clk);
        check("rst_wr busy", o_busy, 1'b0);
        check("rst_wr done", o_done, 1'b0);
        check("rst_wr wc_out", o_wc, 32'h0);
        check("rst_wr mem_addr", o_addr, 32'h0);
        reset = 1'b0;
        quiet_window("rst_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
